rx_unescape: RTL and testbench

RX_UNESCAPE -- requirements
Module: rx_unescape

---
 rtl/uart_pkg.sv | 20 ++
 rtl/rx_unescape.sv | 172 +++++++++++++++++
 tb/tb_rx_unescape.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions, used by the RX unescaper and the TX escaper.
//
// Contents:
//   ESC_DEFAULT  - default escape byte value
//   esc_state_e  - escape-decoder state encoding
//   is_esc_byte  - compare a byte against the active escape value
package uart_pkg;

  localparam logic [7:0] ESC_DEFAULT = 8'hB1;

  typedef enum logic {
    IDLE     = 1'b0,
    ESC_SEEN = 1'b1
  } esc_state_e;

  function automatic logic is_esc_byte(input logic [7:0] b, input logic [7:0] esc);
    return (b == esc);
  endfunction

endpackage

// File: rtl/rx_unescape.sv
// rx_unescape - splits a UART-RX byte stream into data bytes and commands.
//
// An ESC byte introduces a two-byte sequence: ESC ESC is a literal ESC data
// byte, ESC <other> is a command. Data goes to a one-entry buffer read by the
// TAP; commands bypass the buffer and are strobed for one cycle.
//
// Optional feature: define RX_UNESCAPE_TIMEOUT_EN to abandon a pending ESC
// after TIMEOUT_CYCLES cycles without a received byte.
//
// Parameters:
//   ESC             escape byte value
//   TIMEOUT_CYCLES  idle cycles after ESC before giving up (timeout build only)
//
// Ports:
//   CLK_I           clock, rising edge
//   RST_I           synchronous active-high reset
//   RX_DATA_I       byte from UART-RX
//   RX_VALID_I      one-cycle strobe per received byte
//   DATA_REC_O      unescaped data byte
//   DATA_VALID_O    DATA_REC_O holds an unread byte
//   READ_I          consumer takes the held byte
//   COMMAND_O       last received command byte
//   CMD_VALID_O     one-cycle command strobe
//   ESC_DETECTED_O  high while an ESC is pending
//   OVERRUN_O       one-cycle pulse when a data byte is dropped
//   TIMEOUT_O       one-cycle pulse when a pending ESC times out
//
// State table:
//   state    | meaning
//   IDLE     | no escape pending; plain bytes are data
//   ESC_SEEN | ESC received; next byte is a literal ESC or a command
module rx_unescape
  import uart_pkg::*;
#(
  parameter logic [7:0] ESC            = ESC_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic [7:0] RX_DATA_I,
  input  logic       RX_VALID_I,
  output logic [7:0] DATA_REC_O,
  output logic       DATA_VALID_O,
  input  logic       READ_I,
  output logic [7:0] COMMAND_O,
  output logic       CMD_VALID_O,
  output logic       ESC_DETECTED_O,
  output logic       OVERRUN_O,
  output logic       TIMEOUT_O
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("rx_unescape: TIMEOUT_CYCLES must be at least 1");
  end

  esc_state_e state_q, state_d;
  logic       rx_is_esc;
  logic       data_take;
  logic       cmd_take;
  logic       tmo_fire;

  assign rx_is_esc = is_esc_byte(RX_DATA_I, ESC);

`ifdef RX_UNESCAPE_TIMEOUT_EN
  // Counter holds the number of idle cycles already spent in ESC_SEEN.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] tmo_cnt_q;
`endif

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    data_take = 1'b0;
    cmd_take  = 1'b0;
    tmo_fire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (RX_VALID_I) begin
          if (rx_is_esc) begin
            state_d = ESC_SEEN;
          end else begin
            data_take = 1'b1;
          end
        end
      end
      ESC_SEEN: begin
        // A byte arriving on the expiry cycle wins over the timeout.
        if (RX_VALID_I) begin
          state_d = IDLE;
          if (rx_is_esc) begin
            data_take = 1'b1;
          end else begin
            cmd_take = 1'b1;
          end
        end
`ifdef RX_UNESCAPE_TIMEOUT_EN
        else if (tmo_cnt_q == CNT_LAST) begin
          state_d  = IDLE;
          tmo_fire = 1'b1;
        end
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ESC_DETECTED_O = (state_q == ESC_SEEN);

  // One-entry data buffer. A coincident read frees the slot for the new
  // byte; otherwise a byte arriving into a full buffer is dropped.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      DATA_REC_O   <= 8'h00;
      DATA_VALID_O <= 1'b0;
      OVERRUN_O    <= 1'b0;
    end else begin
      OVERRUN_O <= 1'b0;
      if (data_take) begin
        if (!DATA_VALID_O || READ_I) begin
          DATA_REC_O   <= RX_DATA_I;
          DATA_VALID_O <= 1'b1;
        end else begin
          OVERRUN_O <= 1'b1;
        end
      end else if (DATA_VALID_O && READ_I) begin
        DATA_VALID_O <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      COMMAND_O   <= 8'h00;
      CMD_VALID_O <= 1'b0;
    end else begin
      CMD_VALID_O <= cmd_take;
      if (cmd_take) begin
        COMMAND_O <= RX_DATA_I;
      end
    end
  end

`ifdef RX_UNESCAPE_TIMEOUT_EN
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      tmo_cnt_q <= '0;
      TIMEOUT_O <= 1'b0;
    end else begin
      TIMEOUT_O <= tmo_fire;
      if (state_q == ESC_SEEN && !RX_VALID_I && !tmo_fire) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end else begin
        tmo_cnt_q <= '0;
      end
    end
  end
`else
  assign TIMEOUT_O = 1'b0;
`endif

endmodule

// File: tb/tb_rx_unescape.sv
// Directed bench for rx_unescape. Expected data bytes and commands are pushed
// into scoreboard queues when the stimulus is driven and popped when the DUT
// presents them.
module tb_rx_unescape;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       read;
  logic [7:0] data_rec;
  logic       data_valid;
  logic [7:0] command;
  logic       cmd_valid;
  logic       esc_detected;
  logic       overrun;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_data[$];
  logic [7:0] exp_cmd[$];

  always #5 clk = ~clk;

  rx_unescape #(
    .ESC           (8'hB1),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .CLK_I         (clk),
    .RST_I         (rst),
    .RX_DATA_I     (rx_data),
    .RX_VALID_I    (rx_valid),
    .DATA_REC_O    (data_rec),
    .DATA_VALID_O  (data_valid),
    .READ_I        (read),
    .COMMAND_O     (command),
    .CMD_VALID_O   (cmd_valid),
    .ESC_DETECTED_O(esc_detected),
    .OVERRUN_O     (overrun),
    .TIMEOUT_O     (timeout)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic rd);
    rx_valid = v;
    rx_data  = d;
    read     = rd;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    read     = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  // Byte expected to land in the data buffer.
  task automatic send_data(input logic [7:0] d, input logic rd);
    exp_data.push_back(d);
    step(1'b1, d, rd);
  endtask

  task automatic check_data(input string tag);
    logic [7:0] e;
    chk({tag, "_valid"}, 8'(data_valid), 8'h01);
    if (exp_data.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed byte %0h expected none queued", tag, data_rec);
    end else begin
      e = exp_data.pop_front();
      chk({tag, "_data"}, data_rec, e);
    end
  endtask

  task automatic check_cmd(input string tag);
    logic [7:0] e;
    chk({tag, "_strobe"}, 8'(cmd_valid), 8'h01);
    if (exp_cmd.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed command %0h expected none queued", tag, command);
    end else begin
      e = exp_cmd.pop_front();
      chk({tag, "_cmd"}, command, e);
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    read     = 1'b0;
    idle(2);

    chk("rst_data",    data_rec, 8'h00);
    chk("rst_valid",   8'(data_valid), 8'h00);
    chk("rst_cmd",     command, 8'h00);
    chk("rst_cmd_vld", 8'(cmd_valid), 8'h00);
    chk("rst_esc",     8'(esc_detected), 8'h00);
    chk("rst_ovr",     8'(overrun), 8'h00);
    chk("rst_tmo",     8'(timeout), 8'h00);
    rst = 1'b0;
    idle(1);

    // Plain bytes, read after each, valid one cycle after the strobe.
    send_data(8'h41, 1'b0);
    check_data("plain_41");
    idle(1);
    chk("plain_41_held", data_rec, 8'h41);
    chk("plain_41_held_vld", 8'(data_valid), 8'h01);
    step(1'b0, 8'h00, 1'b1);
    chk("plain_41_read", 8'(data_valid), 8'h00);
    send_data(8'h42, 1'b0);
    check_data("plain_42");
    step(1'b0, 8'h00, 1'b1);
    chk("plain_42_read", 8'(data_valid), 8'h00);

    // Read while empty is ignored.
    step(1'b0, 8'h00, 1'b1);
    chk("read_empty_vld", 8'(data_valid), 8'h00);
    chk("read_empty_ovr", 8'(overrun), 8'h00);

    // ESC ESC -> literal ESC data byte, no command.
    step(1'b1, 8'hB1, 1'b0);
    chk("escesc_pending", 8'(esc_detected), 8'h01);
    chk("escesc_no_data", 8'(data_valid), 8'h00);
    send_data(8'hB1, 1'b0);
    check_data("escesc");
    chk("escesc_no_cmd", 8'(cmd_valid), 8'h00);
    chk("escesc_esc_clr", 8'(esc_detected), 8'h00);
    step(1'b0, 8'h00, 1'b1);
    chk("escesc_read", 8'(data_valid), 8'h00);

    // ESC 05 with a full buffer: command delivered, buffer untouched.
    send_data(8'h33, 1'b0);
    check_data("cmd_pre");
    exp_data.push_front(8'h33);
    step(1'b1, 8'hB1, 1'b0);
    exp_cmd.push_back(8'h05);
    step(1'b1, 8'h05, 1'b0);
    check_cmd("cmd_05");
    chk("cmd_05_no_ovr", 8'(overrun), 8'h00);
    check_data("cmd_buf_kept");
    idle(1);
    chk("cmd_05_one_pulse", 8'(cmd_valid), 8'h00);
    chk("cmd_05_held", command, 8'h05);
    step(1'b0, 8'h00, 1'b1);
    chk("cmd_buf_read", 8'(data_valid), 8'h00);

    // Overrun: 10 unread, 20 dropped.
    send_data(8'h10, 1'b0);
    check_data("ovr_first");
    exp_data.push_front(8'h10);
    step(1'b1, 8'h20, 1'b0);
    chk("ovr_pulse", 8'(overrun), 8'h01);
    check_data("ovr_kept");
    idle(1);
    chk("ovr_one_pulse", 8'(overrun), 8'h00);
    // Same again with a coincident read: new byte loaded, no overrun.
    send_data(8'h20, 1'b1);
    check_data("swap_20");
    chk("swap_no_ovr", 8'(overrun), 8'h00);
    step(1'b0, 8'h00, 1'b1);
    chk("swap_read", 8'(data_valid), 8'h00);

    // Reset mid-operation drops pending ESC and unread byte.
    send_data(8'h55, 1'b0);
    step(1'b1, 8'hB1, 1'b0);
    chk("rstmid_esc", 8'(esc_detected), 8'h01);
    check_data("rstmid_pre");
    rst = 1'b1;
    step(1'b1, 8'h77, 1'b0);
    rst = 1'b0;
    chk("rstmid_esc_clr", 8'(esc_detected), 8'h00);
    chk("rstmid_vld_clr", 8'(data_valid), 8'h00);
    send_data(8'h05, 1'b0);
    check_data("rstmid_05");
    chk("rstmid_no_cmd", 8'(cmd_valid), 8'h00);
    step(1'b0, 8'h00, 1'b1);

`ifdef RX_UNESCAPE_TIMEOUT_EN
    // Four idle cycles after ESC -> timeout, then 05 is plain data.
    step(1'b1, 8'hB1, 1'b0);
    idle(3);
    chk("tmo_not_yet", 8'(timeout), 8'h00);
    chk("tmo_still_esc", 8'(esc_detected), 8'h01);
    idle(1);
    chk("tmo_pulse", 8'(timeout), 8'h01);
    chk("tmo_esc_clr", 8'(esc_detected), 8'h00);
    idle(1);
    chk("tmo_one_pulse", 8'(timeout), 8'h00);
    send_data(8'h05, 1'b0);
    check_data("tmo_05");
    chk("tmo_05_no_cmd", 8'(cmd_valid), 8'h00);
    step(1'b0, 8'h00, 1'b1);
    // A byte on the expiry cycle beats the timeout.
    step(1'b1, 8'hB1, 1'b0);
    idle(3);
    exp_cmd.push_back(8'h06);
    step(1'b1, 8'h06, 1'b0);
    check_cmd("tmo_race_cmd");
    chk("tmo_race_no_tmo", 8'(timeout), 8'h00);
`else
    // Without the timeout the ESC waits indefinitely.
    step(1'b1, 8'hB1, 1'b0);
    idle(10);
    chk("notmo_esc_held", 8'(esc_detected), 8'h01);
    chk("notmo_tmo_low", 8'(timeout), 8'h00);
    exp_cmd.push_back(8'h06);
    step(1'b1, 8'h06, 1'b0);
    check_cmd("notmo_cmd");
`endif
    idle(1);

    chk("sb_data_drained", 8'(exp_data.size()), 8'h00);
    chk("sb_cmd_drained", 8'(exp_cmd.size()), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
